word_uart_tx: RTL



---
 rtl/word_uart_tx.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/word_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : word_uart_tx                                                 |
// | Description : Serialises a 32-bit word as NUM_BYTES UART frames on TxD.    |
// |               Optional even-parity bit via WORD_UART_TX_PARITY_EN.         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module word_uart_tx #(
    parameter int CLKS_PER_BIT   = 87,
    parameter int NUM_BYTES      = 4,
    parameter int MSB_BYTE_FIRST = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_in,
    input  logic        dval,
    output logic        ready,
    output logic        TxD,
    output logic        busy,
    output logic        tx_done
);

    localparam int                  c_BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [1:0]          c_LAST_BYTE = 2'(NUM_BYTES - 1);

`ifdef WORD_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;
`endif

    state_t              r_state;
    state_t              w_state_next;
    logic [c_BAUD_W-1:0] r_baud;
    logic [2:0]          r_bit_cnt;
    logic [2:0]          w_bit_next;
    logic [1:0]          r_byte_cnt;
    logic [31:0]         r_shift;
    logic [31:0]         w_shift_adv;
    logic [7:0]          w_cur_byte;
    logic                r_txd;
    logic                w_txd_next;
    logic                r_tx_done;
    logic                w_done_next;
    logic                w_accept;
    logic                w_baud_end;
    logic                w_last_byte;

    // The byte on the wire always sits at one end of the shift register.
    generate
        if (MSB_BYTE_FIRST != 0) begin : g_msb_first
            assign w_cur_byte  = r_shift[31:24];
            assign w_shift_adv = {r_shift[23:0], 8'h00};
        end else begin : g_lsb_first
            assign w_cur_byte  = r_shift[7:0];
            assign w_shift_adv = {8'h00, r_shift[31:8]};
        end
    endgenerate

    assign w_accept    = (r_state == IDLE) && dval;
    assign w_baud_end  = (r_baud == c_BAUD_LAST);
    assign w_last_byte = (r_byte_cnt == c_LAST_BYTE);

    always_comb begin
        w_state_next = r_state;
        w_bit_next   = r_bit_cnt;
        w_done_next  = 1'b0;
        w_txd_next   = 1'b1;
        case (r_state)
            IDLE: begin
                if (dval) w_state_next = START;
            end
            START: begin
                if (w_baud_end) begin
                    w_state_next = DATA;
                    w_bit_next   = 3'd0;
                end
            end
            DATA: begin
                if (w_baud_end) begin
                    if (r_bit_cnt == 3'd7) begin
`ifdef WORD_UART_TX_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                    end else begin
                        w_bit_next = r_bit_cnt + 3'd1;
                    end
                end
            end
`ifdef WORD_UART_TX_PARITY_EN
            PARITY: begin
                if (w_baud_end) w_state_next = STOP;
            end
`endif
            STOP: begin
                if (w_baud_end) begin
                    if (w_last_byte) begin
                        w_state_next = IDLE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_state_next = START;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase

        // Line level is derived from the upcoming state so TxD stays a pure flop.
        case (w_state_next)
            START:   w_txd_next = 1'b0;
            DATA:    w_txd_next = w_cur_byte[w_bit_next];
`ifdef WORD_UART_TX_PARITY_EN
            PARITY:  w_txd_next = ^w_cur_byte;
`endif
            default: w_txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_baud     <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_shift    <= '0;
            r_txd      <= 1'b1;
            r_tx_done  <= 1'b0;
        end else begin
            r_txd     <= w_txd_next;
            r_tx_done <= w_done_next;
            r_bit_cnt <= w_bit_next;
            if (w_accept) begin
                r_shift    <= data_in;
                r_byte_cnt <= '0;
                r_baud     <= '0;
            end else if (r_state != IDLE) begin
                r_baud <= w_baud_end ? '0 : r_baud + 1'b1;
                if ((r_state == STOP) && w_baud_end && !w_last_byte) begin
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                    r_shift    <= w_shift_adv;
                end
            end
        end
    end

    assign ready   = (r_state == IDLE) && !reset;
    assign busy    = (r_state != IDLE);
    assign TxD     = r_txd;
    assign tx_done = r_tx_done;

endmodule
`default_nettype wire
